// File: rtl/sccb_config_sequencer_if.sv
// Signal bundle tying the config sequencer to its host, its table ROM and the SCCB write master.
// The master modport is the sequencer's view; slave is the environment's view.
interface sccb_config_sequencer_if #(
    parameter int ROM_AW = 6
);
    logic              config_start;
    logic              config_busy;
    logic              config_done;
    logic              config_error;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_start;
    logic [7:0]        sccb_addr;
    logic [7:0]        sccb_data;
    logic              sccb_done;
    logic [7:0]        write_count;

    modport master (
        input  config_start, rom_data, sccb_done,
        output config_busy, config_done, config_error, rom_addr,
               sccb_start, sccb_addr, sccb_data, write_count
    );

    modport slave (
        output config_start, rom_data, sccb_done,
        input  config_busy, config_done, config_error, rom_addr,
               sccb_start, sccb_addr, sccb_data, write_count
    );
endinterface

// File: rtl/sccb_config_sequencer.sv
// Walks a ROM table of {reg_addr, reg_data} camera writes, handing each to the SCCB master
// one at a time, honouring delay markers, a post-write bus gap and a per-write timeout.
module sccb_config_sequencer #(
    parameter int NUM_ENTRIES    = 64,
    parameter int ROM_AW         = 6,
    parameter int POWERUP_CYCLES = 50000,
    parameter int DELAY_CYCLES   = 500000,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    sccb_config_sequencer_if.master bus
);
    localparam int MAX_A    = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
    localparam int MAX_B    = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [TW-1:0]     PWR_LAST  = TW'(POWERUP_CYCLES - 1);
    localparam logic [TW-1:0]     DLY_LAST  = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(NUM_ENTRIES - 1);
    localparam logic [15:0]       ENT_END   = 16'hFFFF;
    localparam logic [15:0]       ENT_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE,
        S_GAP, S_DELAY, S_ADVANCE, S_FINISH, S_ERROR
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_sccb_start;
    logic [7:0]        r_sccb_addr;
    logic [7:0]        r_sccb_data;
    logic [7:0]        r_write_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_rom_addr    <= '0;
            r_sccb_start  <= 1'b0;
            r_sccb_addr   <= '0;
            r_sccb_data   <= '0;
            r_write_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.config_start) begin
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                        r_write_count <= '0;
                        r_rom_addr    <= '0;
                        r_busy        <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= (POWERUP_CYCLES == 0) ? S_FETCH : S_PWRUP;
                    end
                end
                S_PWRUP: begin
                    if (r_timer == PWR_LAST) r_state <= S_FETCH;
                    else                     r_timer <= r_timer + 1'b1;
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_timer <= '0;
                    if (bus.rom_data == ENT_END) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end else if (bus.rom_data == ENT_DELAY) begin
                        r_state <= (DELAY_CYCLES == 0) ? S_ADVANCE : S_DELAY;
                    end else begin
                        r_sccb_addr  <= bus.rom_data[15:8];
                        r_sccb_data  <= bus.rom_data[7:0];
                        r_sccb_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                // Timer runs from the start-pulse cycle, so the timeout fires TIMEOUT_CYCLES after it.
                S_ISSUE: begin
                    r_sccb_start <= 1'b0;
                    r_timer      <= r_timer + 1'b1;
                    r_state      <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.sccb_done) begin
                        if (r_write_count != 8'hFF) r_write_count <= r_write_count + 1'b1;
                        r_timer <= '0;
                        r_state <= (GAP_CYCLES == 0) ? S_ADVANCE : S_GAP;
                    end else if (r_timer >= TO_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == GAP_LAST) r_state <= S_ADVANCE;
                    else                     r_timer <= r_timer + 1'b1;
                end
                S_DELAY: begin
                    if (r_timer == DLY_LAST) r_state <= S_ADVANCE;
                    else                     r_timer <= r_timer + 1'b1;
                end
                S_ADVANCE: begin
                    if (r_rom_addr == LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                S_ERROR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.config_busy  = r_busy;
    assign bus.config_done  = r_done;
    assign bus.config_error = r_error;
    assign bus.rom_addr     = r_rom_addr;
    assign bus.sccb_start   = r_sccb_start;
    assign bus.sccb_addr    = r_sccb_addr;
    assign bus.sccb_data    = r_sccb_data;
    assign bus.write_count  = r_write_count;
endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Upstream feeder for the SCCB write master: walks a table of camera register writes, issues one {addr,data} write per entry, waits for the master's done pulse, and reports configuration complete/error.
- Table lives in an external synchronous ROM (1-cycle read latency), 16-bit entries {reg_addr[15:8], reg_data[7:0]}.
- Supports delay markers, for example after a soft-reset write, and a per-write timeout.

Parameters:
- NUM_ENTRIES, 64, table depth; the walk stops after this many entries even without a sentinel.
- ROM_AW, 6, rom_addr width; must satisfy 2^ROM_AW >= NUM_ENTRIES.
- POWERUP_CYCLES, 50000, wait after start before the first fetch; 0 means no wait.
- DELAY_CYCLES, 500000, wait for a delay-marker entry.
- GAP_CYCLES, 1000, bus idle time after each completed write.
- TIMEOUT_CYCLES, 200000, maximum wait for sccb_done after an sccb_start pulse.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- config_start  in  1  begin sequence; sampled only in IDLE
- config_busy  out  1  high from start acceptance until FINISH/ERROR
- config_done  out  1  level; sequence completed without error
- config_error  out  1  level; a write timed out
- rom_addr  out  ROM_AW  table index
- rom_data  in  16  entry at rom_addr, valid 1 cycle after rom_addr changes
- sccb_start  out  1  one-cycle pulse to the SCCB master
- sccb_addr  out  8  register address to the master
- sccb_data  out  8  register data to the master
- sccb_done  in  1  one-cycle completion pulse from the master
- write_count  out  8  completed writes this run; saturates at 255

Behaviour:
- Reset (synchronous, active-high) sets all outputs to 0, clears all counters, and enters IDLE. Reset in any state, including WAIT_DONE, aborts the run on the next edge.
- Entry encodings:
  - 16'hFFFF = end of table.
  - 16'hFFF0 = delay marker.
  - Anything else = register write.
- State transitions:
  - IDLE: config_busy=0. When config_start=1: clear config_done, config_error, write_count; set rom_addr=0 and busy=1; go to PWRUP.
  - PWRUP: count POWERUP_CYCLES cycles, then go to FETCH.
  - FETCH: holds one cycle for the ROM read latency, then goes to DECODE.
  - DECODE: sample rom_data.
    - FFFF: go to FINISH.
    - FFF0: go to DELAY.
    - Otherwise: latch sccb_addr=rom_data[15:8] and sccb_data=rom_data[7:0]; go to ISSUE.
  - ISSUE: sccb_start=1 for exactly this one cycle; clear the timer; go to WAIT_DONE.
  - WAIT_DONE: sccb_addr and sccb_data stay stable.
    - sccb_done=1: increment write_count; go to GAP.
    - Timer reaches TIMEOUT_CYCLES: go to ERROR.
    - If done and timeout occur in the same cycle, done wins.
  - GAP: wait GAP_CYCLES, then ADVANCE.
  - DELAY: wait DELAY_CYCLES, then ADVANCE.
  - ADVANCE (single cycle):
    - If rom_addr==NUM_ENTRIES-1: go to FINISH.
    - Otherwise: rom_addr+1, go to FETCH.
  - FINISH: set config_done=1 and busy=0; go to IDLE. done holds until the next accepted start or reset.
  - ERROR: set config_error=1 and busy=0; rom_addr freezes at the failing index for debug; go to IDLE. error holds until the next accepted start or reset.
- config_start while busy is ignored. A level-high start in IDLE after FINISH/ERROR re-runs the sequence.
- sccb_done outside WAIT_DONE is ignored and does not count.
- sccb_start is never asserted outside ISSUE. At most one write is outstanding.
- Wait counters: one shared down/up counter wide enough for max(POWERUP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES). A wait of N cycles means exactly N cycles spent in that state.
- config_done and config_error are never high simultaneously.

Test Plan:
- Bench parameters: POWERUP=4, GAP=3, DELAY=20, TIMEOUT=50, NUM_ENTRIES=8. Stub master pulses sccb_done 10 cycles after each sccb_start.
- ROM {1280,1101,40D0,FFFF}, start -> exactly 3 sccb_start pulses carrying (12,80),(11,01),(40,D0); each pair is stable until its done; config_done=1; write_count=3; busy=0.
- ROM {1280,FFF0,1101,FFFF} -> interval from the done of write 1 to the start of write 2 = GAP+DELAY+fixed FETCH/DECODE/ISSUE overhead; exact cycle count is checked; write_count=2.
- Stub never answers on entry 1 -> config_error=1 exactly 50 cycles after the second sccb_start; rom_addr=1; write_count=1; no further sccb_start; done=0.
- Pulse config_start while busy -> no effect. After FINISH, start again -> rerun from rom_addr 0; done and write_count cleared on acceptance.
- Reset asserted mid WAIT_DONE, and separately stub done and timeout coinciding in one cycle -> reset: all outputs 0 next cycle, IDLE. Coincidence: counted as success, no error.
- ROM with 8 writes and no sentinel -> stops after 8 writes with config_done=1; rom_addr never exceeds 7.
